// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the multi-cycle control FSM.
//   state_t    : FSM state (FETCH/DECODE/EXEC/WB)
//   OP_*/FN_*  : opcode and R-type function field values
//   ALU_*      : alu_con operation codes
//   SIGN_*     : sign-extend mode encodings
//   ctrl_t     : decoded datapath control bundle
package ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    WB     = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_IMM   = 6'b111111;

  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1100;
  localparam logic [3:0] ALU_IMM = 4'b1110;

  localparam logic [1:0] SIGN_NONE  = 2'b00;
  localparam logic [1:0] SIGN_IMM   = 2'b10;
  localparam logic [1:0] SIGN_SHAMT = 2'b11;

  typedef struct packed {
    logic [1:0] sign;
    logic       alu_src;
    logic [3:0] alu_con;
    logic       choose_reg;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational instruction decoder.
//   opcode, func : instruction fields from the instruction register
//   ctrl         : decoded datapath controls (all zero when undecodable)
//   is_shift     : sll/srl, selects the shift EXEC length
//   is_legal     : instruction is in the decode table
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  output ctrl_t      ctrl,
  output logic       is_shift,
  output logic       is_legal
);

  always_comb begin
    ctrl     = '0;
    is_shift = 1'b0;
    is_legal = 1'b1;
    if (opcode == OP_IMM) begin
      ctrl = '{sign: SIGN_IMM, alu_src: 1'b1, alu_con: ALU_IMM, choose_reg: 1'b0};
    end else if (opcode == OP_RTYPE) begin
      case (func)
        FN_SLL: begin
          ctrl     = '{sign: SIGN_SHAMT, alu_src: 1'b1, alu_con: ALU_SLL, choose_reg: 1'b1};
          is_shift = 1'b1;
        end
        FN_SRL: begin
          ctrl     = '{sign: SIGN_SHAMT, alu_src: 1'b1, alu_con: ALU_SRL, choose_reg: 1'b1};
          is_shift = 1'b1;
        end
        FN_ADD: ctrl = '{sign: SIGN_NONE, alu_src: 1'b0, alu_con: ALU_ADD, choose_reg: 1'b1};
        FN_SUB: ctrl = '{sign: SIGN_NONE, alu_src: 1'b0, alu_con: ALU_SUB, choose_reg: 1'b1};
        FN_AND: ctrl = '{sign: SIGN_NONE, alu_src: 1'b0, alu_con: ALU_AND, choose_reg: 1'b1};
        FN_OR:  ctrl = '{sign: SIGN_NONE, alu_src: 1'b0, alu_con: ALU_OR,  choose_reg: 1'b1};
        default: is_legal = 1'b0;
      endcase
    end else begin
      is_legal = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: FETCH -> DECODE -> EXEC -> WB control sequencer.
//   clk, rst            : clock, synchronous active-high reset
//   instr_valid/ready   : instruction handshake (ready only in FETCH)
//   opcode, func        : instruction fields, latched on transfer
//   stall               : freezes the EXEC counter
//   sign/alu_src/alu_con/choose_reg : registered datapath controls
//   reg_write           : WB pulse for legal instructions
//   busy                : high in DECODE/EXEC/WB
//   done                : WB pulse for every instruction
//   illegal             : WB pulse for undecodable instructions
// Build option: define CTRL_ILLEGAL_TRAP_EN to flag undecodable instructions
// on 'illegal'; otherwise they run as NOPs and 'illegal' stays 0.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int ALU_CYCLES   = 1,
  parameter int SHIFT_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       stall,
  output logic [1:0] sign,
  output logic       alu_src,
  output logic [3:0] alu_con,
  output logic       choose_reg,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  // Counter holds remaining EXEC cycles minus one, so 0 means "last cycle".
  localparam logic [CNT_W-1:0] ALU_LOAD   = CNT_W'(ALU_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(SHIFT_CYCLES - 1);

  state_t           state;
  logic [5:0]       ir_op;
  logic [5:0]       ir_func;
  logic [CNT_W-1:0] cnt;
  logic             legal_q;

  ctrl_t dec_ctrl;
  logic  dec_shift;
  logic  dec_legal;

  ctrl_decode u_decode (
    .opcode   (ir_op),
    .func     (ir_func),
    .ctrl     (dec_ctrl),
    .is_shift (dec_shift),
    .is_legal (dec_legal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      ir_op       <= '0;
      ir_func     <= '0;
      cnt         <= '0;
      legal_q     <= 1'b0;
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      sign        <= '0;
      alu_src     <= 1'b0;
      alu_con     <= '0;
      choose_reg  <= 1'b0;
      reg_write   <= 1'b0;
      done        <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (instr_valid && instr_ready) begin
            ir_op       <= opcode;
            ir_func     <= func;
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            state       <= DECODE;
          end
        end
        DECODE: begin
          sign       <= dec_ctrl.sign;
          alu_src    <= dec_ctrl.alu_src;
          alu_con    <= dec_ctrl.alu_con;
          choose_reg <= dec_ctrl.choose_reg;
          legal_q    <= dec_legal;
          cnt        <= dec_shift ? SHIFT_LOAD : ALU_LOAD;
          state      <= EXEC;
        end
        EXEC: begin
          if (!stall) begin
            if (cnt == '0) begin
              // WB pulses are registered here so they are valid for the whole WB cycle.
              done      <= 1'b1;
              reg_write <= legal_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
              illegal   <= !legal_q;
`endif
              state     <= WB;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
        end
        WB: begin
          done        <= 1'b0;
          reg_write   <= 1'b0;
          illegal     <= 1'b0;
          sign        <= '0;
          alu_src     <= 1'b0;
          alu_con     <= '0;
          choose_reg  <= 1'b0;
          busy        <= 1'b0;
          instr_ready <= 1'b1;
          state       <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm (ALU_CYCLES=1, SHIFT_CYCLES=3).
module tb_multicycle_ctrl_fsm;

  localparam int ALU_CYCLES   = 1;
  localparam int SHIFT_CYCLES = 3;
  localparam int NSTALL       = 8192;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       stall;
  logic [1:0] sign;
  logic       alu_src;
  logic [3:0] alu_con;
  logic       choose_reg;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       illegal;

  multicycle_ctrl_fsm #(
    .ALU_CYCLES   (ALU_CYCLES),
    .SHIFT_CYCLES (SHIFT_CYCLES),
    .CNT_W        (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .opcode      (opcode),
    .func        (func),
    .stall       (stall),
    .sign        (sign),
    .alu_src     (alu_src),
    .alu_con     (alu_con),
    .choose_reg  (choose_reg),
    .reg_write   (reg_write),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // cyc == k during the cycle that follows rising edge k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         a;      // accepting edge
    int         wb;     // cycle in which done must be high
    int         len;    // EXEC length
    logic [7:0] ctl;    // {sign, alu_src, alu_con, choose_reg}
    logic       rw;
    logic       ill;
  } exp_t;

  exp_t q[$];
  bit   stall_arr[NSTALL];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   track_en = 1'b1;
  bit   have_prev = 1'b0;
  int   prev_wb = 0;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference decode straight from the instruction table.
  function automatic exp_t ref_decode(input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    e.a = 0;
    e.wb = 0;
    e.len = ALU_CYCLES;
    e.rw = 1'b1;
    e.ill = 1'b0;
    e.ctl = 8'h00;
    if (op == 6'b111111)      e.ctl = {2'b10, 1'b1, 4'b1110, 1'b0};
    else if (op == 6'b000000) begin
      case (fn)
        6'b000000: begin e.ctl = {2'b11, 1'b1, 4'b1000, 1'b1}; e.len = SHIFT_CYCLES; end
        6'b000010: begin e.ctl = {2'b11, 1'b1, 4'b1100, 1'b1}; e.len = SHIFT_CYCLES; end
        6'b100000: e.ctl = {2'b00, 1'b0, 4'b0010, 1'b1};
        6'b100010: e.ctl = {2'b00, 1'b0, 4'b0100, 1'b1};
        6'b100100: e.ctl = {2'b00, 1'b0, 4'b0000, 1'b1};
        6'b100101: e.ctl = {2'b00, 1'b0, 4'b0001, 1'b1};
        default:   e.rw = 1'b0;
      endcase
    end else e.rw = 1'b0;
    if (!e.rw) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      e.ill = 1'b1;
`else
      e.ill = 1'b0;
`endif
    end
    return e;
  endfunction

  // Stall is a per-cycle random schedule known to the model in advance.
  initial begin
    stall = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      stall = stall_arr[cyc % NSTALL];
    end
  end

  task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                       input int gap, input int force_st);
    exp_t e;
    bit   got;
    int   a;
    int   n;
    int   c;
    if (gap > 0) begin
      instr_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    opcode      = op;
    func        = fn;
    instr_valid = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (instr_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      instr_valid = 1'b0;
      return;
    end
    a = cyc + 1;
    @(posedge clk);
    #1;
    if (gap == 0 && have_prev && track_en) chk("b2b_accept_edge", a, prev_wb + 2);
    stall_arr[(a + 1) % NSTALL] = stall_arr[(a + 1) % NSTALL] && (force_st == 0);
    for (int i = 0; i < force_st; i++) stall_arr[(a + 2 + i) % NSTALL] = 1'b1;
    e = ref_decode(op, fn);
    e.a = a;
    n = 0;
    c = a + 1;
    for (int k = 0; k < 1000; k++) begin
      if (!stall_arr[c % NSTALL]) n++;
      if (n == e.len) break;
      c++;
    end
    e.wb = c + 1;
    if (track_en) q.push_back(e);
    prev_wb   = e.wb;
    have_prev = 1'b1;
    instr_valid = 1'b0;
    opcode = 6'($urandom);
    func   = 6'($urandom);
  endtask

  // Monitor: compares every cycle against the oldest outstanding instruction.
  always @(negedge clk) begin
    if (!rst) begin
      if (!track_en) begin
        chk("aborted_done", int'(done), 0);
        chk("aborted_reg_write", int'(reg_write), 0);
      end else if (q.size() > 0 && cyc >= q[0].a) begin
        chk("busy_in_flight", int'(busy), 1);
        chk("ready_in_flight", int'(instr_ready), 0);
        if (cyc > q[0].a)
          chk("controls", int'({sign, alu_src, alu_con, choose_reg}), int'(q[0].ctl));
        if (cyc == q[0].wb) begin
          chk("wb_done", int'(done), 1);
          chk("wb_reg_write", int'(reg_write), int'(q[0].rw));
          chk("wb_illegal", int'(illegal), int'(q[0].ill));
          void'(q.pop_front());
        end else begin
          chk("early_done", int'({done, reg_write, illegal}), 0);
        end
      end else begin
        chk("idle_ready_busy", int'({instr_ready, busy}), 2);
        chk("idle_pulses", int'({done, reg_write, illegal}), 0);
        chk("idle_controls", int'({sign, alu_src, alu_con, choose_reg}), 0);
      end
    end
  end

  initial begin
    rst = 1'b1;
    instr_valid = 1'b0;
    opcode = '0;
    func = '0;
    for (int i = 0; i < NSTALL; i++)
      stall_arr[i] = (i >= 200) && ($urandom_range(0, 2) == 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", int'(instr_ready), 1);
    chk("reset_outputs",
        int'({busy, done, reg_write, illegal, sign, alu_src, alu_con, choose_reg}), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    issue(6'b000000, 6'b100000, 1, 0);  // add
    issue(6'b000000, 6'b000000, 2, 0);  // sll
    issue(6'b000000, 6'b000000, 2, 2);  // sll, 2 stall cycles in EXEC
    issue(6'b000000, 6'b000010, 1, 0);  // srl
    issue(6'b000000, 6'b100010, 0, 0);  // sub
    issue(6'b000000, 6'b100100, 0, 0);  // and
    issue(6'b000000, 6'b100101, 1, 0);  // or
    issue(6'b111111, 6'b010101, 1, 0);  // imm
    issue(6'b111111, 6'b000000, 0, 0);  // imm back-to-back
    issue(6'b000101, 6'b100000, 0, 0);  // illegal opcode
    issue(6'b000000, 6'b111111, 1, 0);  // illegal func

    repeat (150) begin
      logic [5:0] op;
      logic [5:0] fn;
      case ($urandom_range(0, 3))
        0: op = 6'b111111;
        1: op = 6'($urandom);
        default: op = 6'b000000;
      endcase
      case ($urandom_range(0, 6))
        0: fn = 6'b000000;
        1: fn = 6'b000010;
        2: fn = 6'b100000;
        3: fn = 6'b100010;
        4: fn = 6'b100100;
        5: fn = 6'b100101;
        default: fn = 6'($urandom);
      endcase
      issue(op, fn, $urandom_range(0, 2), 0);
    end

    for (int k = 0; k < 200 && q.size() > 0; k++) @(posedge clk);
    chk("drain_queue", q.size(), 0);

    // Abort an sll in EXEC; it must never produce done/reg_write.
    @(posedge clk);
    #1;
    track_en = 1'b0;
    issue(6'b000000, 6'b000000, 1, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(instr_ready), 1);
    chk("abort_outputs",
        int'({busy, done, reg_write, illegal, sign, alu_src, alu_con, choose_reg}), 0);
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
